// File: rtl/npu_instr_issuer.sv
// npu_instr_issuer: expands one LOAD_A/LOAD_B/LOAD_C/COMPUTE command into a
// cycle-accurate instr/data/addr stream for the NPU scheduler and buffers.
// Load beats are paced by an upstream valid/ready stream. COMPUTE runs for
// exactly len cycles and is followed by a fixed drain gap before done.
// Optional macro NPU_ISSUER_STATS_EN adds saturating load/compute counters.
module npu_instr_issuer #(
  parameter int N            = 10,
  parameter int K_SIZE       = 3,
  parameter int W_IN         = 8,
  parameter int W_DATA       = 8,
  parameter int ADDR_W       = 3,
  parameter int LEN_W        = 8,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              cmd_relu,
  input  logic              cmd_bcast,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic              din_valid,
  output logic              din_ready,
  input  logic [W_DATA-1:0] din,
  output logic [W_IN-1:0]   instr,
  output logic [W_DATA-1:0] data_out,
  output logic [ADDR_W-1:0] addr,
  output logic              busy,
  output logic              done,
  output logic              err
`ifdef NPU_ISSUER_STATS_EN
  ,
  output logic [31:0]       stat_load_beats,
  output logic [31:0]       stat_compute_cycles
`endif
);

  localparam logic [1:0]       OP_COMPUTE = 2'd3;
  localparam logic [1:0]       OP_LOAD_C  = 2'd2;
  localparam logic [LEN_W-1:0] MAX_AB     = LEN_W'(N * K_SIZE);
  localparam logic [LEN_W-1:0] MAX_C      = LEN_W'(K_SIZE);
  localparam logic [LEN_W-1:0] DRAIN_LAST = LEN_W'(DRAIN_CYCLES - 1);
  localparam logic [LEN_W-1:0] ONE        = LEN_W'(1);

  typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, DRAIN} state_t;

  state_t            state, state_n;
  logic [LEN_W-1:0]  cnt, cnt_n;
  logic [LEN_W-1:0]  len_q, len_n;
  logic [LEN_W-1:0]  max_len;
  logic [1:0]        mode_q, mode_n;
  logic              relu_q, relu_n;
  logic              bcast_q, bcast_n;
  logic [W_IN-1:0]   instr_n;
  logic [W_DATA-1:0] data_n;
  logic [ADDR_W-1:0] addr_n;
  logic              done_n, err_n;

  assign cmd_ready = (state == IDLE);
  assign din_ready = (state == LOAD);
  // The last load instr is still on the output the cycle the FSM is back in
  // IDLE, so busy also covers any cycle with a non-idle instr on the bus.
  assign busy      = (state != IDLE) || (instr != '0);
  assign max_len   = (cmd_op == OP_LOAD_C) ? MAX_C : MAX_AB;

  // Next-state and next-output logic for the command FSM
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    len_n   = len_q;
    mode_n  = mode_q;
    relu_n  = relu_q;
    bcast_n = bcast_q;
    instr_n = '0;
    data_n  = data_out;
    addr_n  = addr;
    done_n  = 1'b0;
    err_n   = err;
    unique case (state)
      IDLE: begin
        if (cmd_valid) begin
          addr_n  = cmd_addr;
          mode_n  = cmd_op + 2'd1;
          relu_n  = cmd_relu;
          bcast_n = cmd_bcast;
          cnt_n   = '0;
          if (cmd_len == '0) begin
            // Nothing to issue: flag it and complete immediately.
            err_n  = 1'b1;
            done_n = 1'b1;
          end else if (cmd_op == OP_COMPUTE) begin
            len_n   = cmd_len;
            state_n = COMPUTE;
          end else begin
            if (cmd_len > max_len) begin
              len_n = max_len;
              err_n = 1'b1;
            end else begin
              len_n = cmd_len;
            end
            state_n = LOAD;
          end
        end
      end
      LOAD: begin
        // A stalled cycle leaves instr at 0 so the buffer pointer holds.
        if (din_valid) begin
          instr_n[1:0] = mode_q;
          data_n       = din;
          if (cnt + ONE == len_q) begin
            cnt_n   = '0;
            done_n  = 1'b1;
            state_n = IDLE;
          end else begin
            cnt_n = cnt + ONE;
          end
        end
      end
      COMPUTE: begin
        instr_n[4] = 1'b1;
        instr_n[3] = relu_q;
        instr_n[2] = bcast_q;
        if (cnt + ONE == len_q) begin
          cnt_n   = '0;
          state_n = DRAIN;
        end else begin
          cnt_n = cnt + ONE;
        end
      end
      DRAIN: begin
        if (cnt == DRAIN_LAST) begin
          cnt_n   = '0;
          done_n  = 1'b1;
          state_n = IDLE;
        end else begin
          cnt_n = cnt + ONE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State, latched command fields and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      len_q    <= '0;
      mode_q   <= '0;
      relu_q   <= 1'b0;
      bcast_q  <= 1'b0;
      instr    <= '0;
      data_out <= '0;
      addr     <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      len_q    <= len_n;
      mode_q   <= mode_n;
      relu_q   <= relu_n;
      bcast_q  <= bcast_n;
      instr    <= instr_n;
      data_out <= data_n;
      addr     <= addr_n;
      done     <= done_n;
      err      <= err_n;
    end
  end

`ifdef NPU_ISSUER_STATS_EN
  // Saturating counters of issued load and compute instrs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_load_beats     <= '0;
      stat_compute_cycles <= '0;
    end else begin
      if (instr_n[1:0] != 2'd0 && stat_load_beats != '1)
        stat_load_beats <= stat_load_beats + 32'd1;
      if (instr_n[4] && stat_compute_cycles != '1)
        stat_compute_cycles <= stat_compute_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_npu_instr_issuer.sv
// Self-checking bench for npu_instr_issuer: load pacing, clamping, compute
// and drain timing, zero-length commands, mid-command reset.
module tb_npu_instr_issuer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = '0;
  logic [7:0] cmd_len = '0;
  logic       cmd_relu = 1'b0;
  logic       cmd_bcast = 1'b0;
  logic [2:0] cmd_addr = '0;
  logic       din_valid = 1'b0;
  logic       din_ready;
  logic [7:0] din = '0;
  logic [7:0] instr;
  logic [7:0] data_out;
  logic [2:0] addr;
  logic       busy, done, err;
`ifdef NPU_ISSUER_STATS_EN
  logic [31:0] stat_load_beats, stat_compute_cycles;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0] instr;
    logic       done;
  } cexp_t;

  npu_instr_issuer dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_len(cmd_len), .cmd_relu(cmd_relu), .cmd_bcast(cmd_bcast),
    .cmd_addr(cmd_addr), .din_valid(din_valid), .din_ready(din_ready),
    .din(din), .instr(instr), .data_out(data_out), .addr(addr),
    .busy(busy), .done(done), .err(err)
`ifdef NPU_ISSUER_STATS_EN
    , .stat_load_beats(stat_load_beats), .stat_compute_cycles(stat_compute_cycles)
`endif
  );

  always #5 clk = ~clk;

  // Issue one load command and follow it to done, scoreboarding every beat.
  task automatic run_load(input logic [1:0] op, input logic [7:0] len,
                          input int exp_beats, input bit toggle, input logic [2:0] tag);
    logic [7:0] dq[$];
    logic [7:0] e;
    logic [7:0] mode_instr;
    bit prev, seen_done;
    int beats;
    mode_instr = {6'b0, 2'(op + 2'd1)};
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL load_cmd_ready op=%0d got=%b exp=1", op, cmd_ready);
    end
    cmd_valid = 1'b1; cmd_op = op; cmd_len = len; cmd_addr = tag;
    cmd_relu = 1'b0; cmd_bcast = 1'b0; din_valid = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    checks++;
    if ({instr, din_ready, cmd_ready, addr} !== {8'h00, 1'b1, 1'b0, tag}) begin
      errors++;
      $display("FAIL load_accept op=%0d got instr=%h din_ready=%b cmd_ready=%b addr=%0d exp 00/1/0/%0d",
               op, instr, din_ready, cmd_ready, addr, tag);
    end
    prev = 1'b0; beats = 0; seen_done = 1'b0;
    for (int c = 0; c < 200 && !seen_done; c++) begin
      din_valid = toggle ? (c % 2 == 0) : 1'b1;
      din       = toggle ? 8'($urandom) : 8'(c);
      prev      = din_valid && din_ready;
      if (prev) dq.push_back(din);
      @(negedge clk);
      checks++;
      if ((instr != 8'h00) !== prev) begin
        errors++; $display("FAIL load_pacing op=%0d cyc=%0d got instr=%h exp_active=%b", op, c, instr, prev);
      end
      if (instr != 8'h00) begin
        beats++;
        e = (dq.size() != 0) ? dq.pop_front() : 8'hxx;
        checks++;
        if ({instr, data_out, addr} !== {mode_instr, e, tag}) begin
          errors++;
          $display("FAIL load_beat op=%0d beat=%0d got instr=%h data=%h addr=%0d exp %h/%h/%0d",
                   op, beats, instr, data_out, addr, mode_instr, e, tag);
        end
      end
      if (done) begin
        seen_done = 1'b1;
        checks++;
        if (beats != exp_beats || dq.size() != 0 || din_ready !== 1'b0 || busy !== 1'b1 ||
            instr !== mode_instr) begin
          errors++;
          $display("FAIL load_done op=%0d got beats=%0d left=%0d din_ready=%b busy=%b instr=%h exp %0d/0/0/1/%h",
                   op, beats, dq.size(), din_ready, busy, instr, exp_beats, mode_instr);
        end
      end
    end
    din_valid = 1'b0;
    checks++;
    if (!seen_done) begin
      errors++; $display("FAIL load_timeout op=%0d got no done exp done within 200 cycles", op);
    end
    @(negedge clk);
    checks++;
    if ({busy, done, instr} !== {1'b0, 1'b0, 8'h00}) begin
      errors++; $display("FAIL load_tail op=%0d got busy=%b done=%b instr=%h exp 0/0/00", op, busy, done, instr);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({instr, data_out, addr, done, err, busy, cmd_ready, din_ready} !==
        {8'h00, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_state got instr=%h data=%h addr=%0d done=%b err=%b busy=%b cmd_ready=%b din_ready=%b exp 0s, cmd_ready=1",
               instr, data_out, addr, done, err, busy, cmd_ready, din_ready);
    end
    rst_n = 1'b1;
    // din offered in IDLE must not be taken
    din_valid = 1'b1; din = 8'hAA;
    @(negedge clk);
    checks++;
    if ({din_ready, instr, data_out} !== {1'b0, 8'h00, 8'h00}) begin
      errors++; $display("FAIL idle_din got din_ready=%b instr=%h data=%h exp 0/00/00", din_ready, instr, data_out);
    end
    din_valid = 1'b0;
  endtask

  task automatic test_load_a;
    run_load(2'd0, 8'd30, 30, 1'b0, 3'd5);
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL load_a_err got=%b exp=0", err); end
  endtask

  task automatic test_load_b;
    run_load(2'd1, 8'd5, 5, 1'b1, 3'd6);
  endtask

  task automatic test_compute;
    cexp_t q[$];
    cexp_t e;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'd3; cmd_len = 8'd9; cmd_relu = 1'b1; cmd_bcast = 1'b1; cmd_addr = 3'd4;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_relu = 1'b0; cmd_bcast = 1'b0;
    checks++;
    if ({instr, cmd_ready, busy, addr} !== {8'h00, 1'b0, 1'b1, 3'd4}) begin
      errors++; $display("FAIL compute_accept got instr=%h cmd_ready=%b busy=%b addr=%0d exp 00/0/1/4",
                         instr, cmd_ready, busy, addr);
    end
    for (int i = 0; i < 9; i++) q.push_back('{instr: 8'h1C, done: 1'b0});
    for (int i = 0; i < 4; i++) q.push_back('{instr: 8'h00, done: (i == 3)});
    for (int i = 0; i < 13; i++) begin
      // Free-running stalls on din must not affect compute
      din_valid = $urandom_range(0, 1) == 1;
      @(negedge clk);
      e = q.pop_front();
      checks++;
      if ({instr, done} !== {e.instr, e.done} || (i < 12 && cmd_ready !== 1'b0)) begin
        errors++; $display("FAIL compute_cyc%0d got instr=%h done=%b cmd_ready=%b exp %h/%b/0",
                           i, instr, done, cmd_ready, e.instr, e.done);
      end
    end
    din_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({done, busy, err} !== {1'b0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL compute_after got done=%b busy=%b err=%b exp 0/0/0", done, busy, err);
    end
  endtask

  task automatic test_load_c_clamp;
    run_load(2'd2, 8'd7, 3, 1'b0, 3'd1);
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL clamp_err got=%b exp=1", err); end
    run_load(2'd2, 8'd2, 2, 1'b0, 3'd2);
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL err_sticky got=%b exp=1", err); end
  endtask

  task automatic test_mid_reset;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'd0; cmd_len = 8'd30; cmd_addr = 3'd7;
    @(negedge clk);
    cmd_valid = 1'b0;
    din_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin din = 8'(i + 100); @(negedge clk); end
    rst_n = 1'b0;
    din_valid = 1'b0;
    #1;
    checks++;
    if ({instr, data_out, addr, busy, done, err, din_ready} !==
        {8'h00, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL mid_reset got instr=%h data=%h addr=%0d busy=%b done=%b err=%b din_ready=%b exp all 0",
               instr, data_out, addr, busy, done, err, din_ready);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 1) rst_n = 1'b1;
      checks++;
      if ({done, instr} !== {1'b0, 8'h00}) begin
        errors++; $display("FAIL mid_reset_nodone cyc=%0d got done=%b instr=%h exp 0/00", i, done, instr);
      end
    end
    run_load(2'd0, 8'd30, 30, 1'b0, 3'd3);
  endtask

  task automatic test_zero_len;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'd3; cmd_len = 8'd0; cmd_addr = 3'd2;
    @(negedge clk);
    cmd_valid = 1'b0;
    checks++;
    if ({done, err, instr, busy, cmd_ready} !== {1'b1, 1'b1, 8'h00, 1'b0, 1'b1}) begin
      errors++; $display("FAIL zero_len got done=%b err=%b instr=%h busy=%b cmd_ready=%b exp 1/1/00/0/1",
                         done, err, instr, busy, cmd_ready);
    end
    @(negedge clk);
    checks++;
    if ({done, instr} !== {1'b0, 8'h00}) begin
      errors++; $display("FAIL zero_len_after got done=%b instr=%h exp 0/00", done, instr);
    end
  endtask

  task automatic test_back_to_back;
    run_load(2'd1, 8'd30, 30, 1'b0, 3'd4);
    run_load(2'd0, 8'd31, 30, 1'b1, 3'd5);
  endtask

  initial begin
    test_reset();
    test_load_a();
    test_load_b();
    test_compute();
    test_load_c_clamp();
    test_mid_reset();
    test_zero_len();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
